// File: rtl/ili_rect_writer_pkg.sv
// Shared types for the ILI9341 rectangle writer: FSM states, command opcodes,
// the byte-port bundle and a helper that picks one byte out of a coordinate pair.
package ili_rect_writer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_CASET,
    S_DAT_CASET,
    S_CMD_PASET,
    S_DAT_PASET,
    S_CMD_RAMWR,
    S_PIX_HI,
    S_PIX_LO,
    S_FIN
  } state_rect_e;

  localparam logic [7:0] ILI_CMD_CASET = 8'h2A;
  localparam logic [7:0] ILI_CMD_PASET = 8'h2B;
  localparam logic [7:0] ILI_CMD_RAMWR = 8'h2C;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       dc;
  } st_byte_if;

  // Window parameters go out start-hi, start-lo, end-hi, end-lo.
  function automatic logic [7:0] win_byte(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = a[15:8];
      2'd1:    r = a[7:0];
      2'd2:    r = b[15:8];
      default: r = b[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ili_rect_writer.sv
// Rectangle-fill byte source for the ILI9341 SPI path: CASET, PASET, RAMWR, then
// the colour word once per pixel, over a valid/ready byte port with D/C flag.
module ili_rect_writer
  import ili_rect_writer_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int CNT_W  = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_x0,
  input  logic [15:0] i_x1,
  input  logic [15:0] i_y0,
  input  logic [15:0] i_y1,
  input  logic [15:0] i_color,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  input  logic        i_byte_ready,
  output logic        o_cs
);

  state_rect_e      r_state, w_next;
  logic [15:0]      r_x0, r_x1, r_y0, r_y1, r_color;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_pix, r_npix_m1;
  logic             r_err;

  logic             w_bad, w_accept, w_vld, w_xfer;
  logic [CNT_W-1:0] w_wid, w_hgt, w_prod;
  st_byte_if        w_byte;
  logic             w_busy, w_done, w_cs;

  assign w_bad = (i_x0 > i_x1) || (i_y0 > i_y1) ||
                 (i_x1 >= 16'(WIDTH)) || (i_y1 >= 16'(HEIGHT));
  assign w_accept = (r_state == S_IDLE) && i_start && !w_bad;

  // Pixel count is registered in the start cycle and only needed after the header.
  assign w_wid  = CNT_W'(i_x1) - CNT_W'(i_x0) + CNT_W'(1);
  assign w_hgt  = CNT_W'(i_y1) - CNT_W'(i_y0) + CNT_W'(1);
  assign w_prod = w_wid * w_hgt;

  assign w_vld  = (r_state != S_IDLE) && (r_state != S_FIN);
  assign w_xfer = w_vld && i_byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_pix     <= '0;
      r_npix_m1 <= '0;
      r_x0      <= '0;
      r_x1      <= '0;
      r_y0      <= '0;
      r_y1      <= '0;
      r_color   <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_IDLE) && i_start && w_bad;
      if (w_accept) begin
        r_x0      <= i_x0;
        r_x1      <= i_x1;
        r_y0      <= i_y0;
        r_y1      <= i_y1;
        r_color   <= i_color;
        r_npix_m1 <= w_prod - CNT_W'(1);
        r_pix     <= '0;
        r_idx     <= '0;
      end else if (w_xfer) begin
        if (r_state == S_DAT_CASET || r_state == S_DAT_PASET) r_idx <= r_idx + 2'd1;
        if (r_state == S_PIX_LO) r_pix <= r_pix + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_byte = '{valid: w_vld, data: 8'h00, dc: 1'b0};
    w_busy = w_vld;
    w_cs   = !w_vld;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CMD_CASET;
      S_CMD_CASET: begin
        w_byte.data = ILI_CMD_CASET;
        if (w_xfer) w_next = S_DAT_CASET;
      end
      S_DAT_CASET: begin
        w_byte.data = win_byte(r_x0, r_x1, r_idx);
        w_byte.dc   = 1'b1;
        if (w_xfer && r_idx == 2'd3) w_next = S_CMD_PASET;
      end
      S_CMD_PASET: begin
        w_byte.data = ILI_CMD_PASET;
        if (w_xfer) w_next = S_DAT_PASET;
      end
      S_DAT_PASET: begin
        w_byte.data = win_byte(r_y0, r_y1, r_idx);
        w_byte.dc   = 1'b1;
        if (w_xfer && r_idx == 2'd3) w_next = S_CMD_RAMWR;
      end
      S_CMD_RAMWR: begin
        w_byte.data = ILI_CMD_RAMWR;
        if (w_xfer) w_next = S_PIX_HI;
      end
      S_PIX_HI: begin
        w_byte.data = r_color[15:8];
        w_byte.dc   = 1'b1;
        if (w_xfer) w_next = S_PIX_LO;
      end
      S_PIX_LO: begin
        w_byte.data = r_color[7:0];
        w_byte.dc   = 1'b1;
        if (w_xfer) w_next = (r_pix == r_npix_m1) ? S_FIN : S_PIX_HI;
      end
      S_FIN: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_byte_valid = w_byte.valid;
  assign o_byte       = w_byte.data;
  assign o_byte_dc    = w_byte.dc;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_cs         = w_cs;
  assign o_err        = r_err;

endmodule
